// File: rtl/laser_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// laser_sweep_ctrl
//
// Search controller for the LASER block. It loads NPTS points from the X/Y
// stream into a point buffer. It then looks for two circle centres C1 and C2
// that together cover as many points as possible. The search alternates
// between the two circles: C1 is swept over the whole 16x16 grid while C2 is
// held, then C2 is swept while C1 is held, and this repeats until no further
// gain is made. One point is evaluated per cycle. DONE pulses for one cycle
// with the final centres, and the block then returns to loading the next
// image without needing a reset.
//
// Ports
//   CLK            rising-edge clock
//   RST            synchronous reset, active-high; takes priority in every state
//   X, Y [3:0]     point coordinates, sampled only while loading
//   C1X, C1Y [3:0] committed centre 1 (registered)
//   C2X, C2Y [3:0] committed centre 2 (registered)
//   DONE           one-cycle pulse; C1/C2 are final while it is high
// ----------------------------------------------------------------------------
module laser_sweep_ctrl #(
    parameter int NPTS      = 40,
    parameter int RADIUS_SQ = 16,
    parameter int MAX_ITER  = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    localparam int IDX_W = $clog2(NPTS + 1);
    localparam int IT_W  = $clog2(MAX_ITER + 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);
    localparam logic [IDX_W-1:0] NPTS_C   = IDX_W'(NPTS);
    localparam logic [IT_W-1:0]  IT_ZERO  = {IT_W{1'b0}};
    localparam logic [IT_W-1:0]  IT_ONE   = IT_W'(1);
    localparam logic [IT_W-1:0]  MAX_IT_C = IT_W'(MAX_ITER);
    localparam logic [8:0]       RSQ_C    = 9'(RADIUS_SQ);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SWEEP1  = 3'd2,
        ST_COMMIT1 = 3'd3,
        ST_SWEEP2  = 3'd4,
        ST_COMMIT2 = 3'd5,
        ST_FIN     = 3'd6
    } state_t;

    // Coverage test for one point against one centre. The difference is
    // taken as a 5-bit signed value, so there is no wrap-around between
    // opposite edges of the grid; the square of its magnitude fits 8 bits.
    function automatic logic in_radius(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic [4:0]        ndx;
        logic [4:0]        ndy;
        logic [3:0]        ax;
        logic [3:0]        ay;
        logic [7:0]        sqx;
        logic [7:0]        sqy;
        logic [8:0]        sum;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
        ndx = 5'd0 - dx;
        ndy = 5'd0 - dy;
        ax  = dx[4] ? ndx[3:0] : dx[3:0];
        ay  = dy[4] ? ndy[3:0] : dy[3:0];
        sqx = {4'd0, ax} * {4'd0, ax};
        sqy = {4'd0, ay} * {4'd0, ay};
        sum = {1'b0, sqx} + {1'b0, sqy};
        return (sum <= RSQ_C);
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [7:0]       pt_mem_r [NPTS];
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       cand_r;        // {cy, cx}
    logic [IDX_W-1:0] cnt_r;
    logic [7:0]       best_pos_r;    // {y, x}
    logic [IDX_W-1:0] best_cnt_r;
    logic [IDX_W-1:0] cur_cnt_r;
    logic [IT_W-1:0]  iter_r;
    logic [IDX_W-1:0] iter_start_r;
    logic [3:0]       c1x_r;
    logic [3:0]       c1y_r;
    logic [3:0]       c2x_r;
    logic [3:0]       c2y_r;
    logic             done_r;

    logic [7:0]       pt_s;
    logic [3:0]       held_x_s;
    logic [3:0]       held_y_s;
    logic             covered_s;
    logic [IDX_W-1:0] cnt_nx_s;
    logic             last_pt_s;
    logic             last_cand_s;
    logic [IT_W-1:0]  iter_inc_s;

    logic             load_en_s;
    logic             init_en_s;
    logic             sweep_en_s;
    logic             commit1_en_s;
    logic             commit2_en_s;
    logic             done_nx_s;

    // Coverage datapath: current point against the candidate and the held centre.
    always_comb begin
        pt_s     = pt_mem_r[idx_r];
        held_x_s = c2x_r;
        held_y_s = c2y_r;
        if (state_r == ST_SWEEP2) begin
            held_x_s = c1x_r;
            held_y_s = c1y_r;
        end else begin
            held_x_s = c2x_r;
            held_y_s = c2y_r;
        end
        covered_s   = in_radius(pt_s[3:0], pt_s[7:4], cand_r[3:0], cand_r[7:4]) ||
                      in_radius(pt_s[3:0], pt_s[7:4], held_x_s, held_y_s);
        cnt_nx_s    = cnt_r + {{(IDX_W-1){1'b0}}, covered_s};
        last_pt_s   = (idx_r == LAST_IDX);
        last_cand_s = (cand_r == 8'hFF);
        iter_inc_s  = iter_r + IT_ONE;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic. COMMIT decisions use best_cnt_r, which is the value
    // being committed into cur_cnt_r on the same edge.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (idx_r == LAST_IDX) state_nx_s = ST_INIT;
                else                   state_nx_s = ST_LOAD;
            end
            ST_INIT: state_nx_s = ST_SWEEP1;
            ST_SWEEP1: begin
                if (last_pt_s && last_cand_s) state_nx_s = ST_COMMIT1;
                else                          state_nx_s = ST_SWEEP1;
            end
            ST_COMMIT1: begin
                if (best_cnt_r == NPTS_C) state_nx_s = ST_FIN;
                else                      state_nx_s = ST_SWEEP2;
            end
            ST_SWEEP2: begin
                if (last_pt_s && last_cand_s) state_nx_s = ST_COMMIT2;
                else                          state_nx_s = ST_SWEEP2;
            end
            ST_COMMIT2: begin
                if ((best_cnt_r == NPTS_C) || (best_cnt_r == iter_start_r) ||
                    (iter_inc_s == MAX_IT_C)) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_SWEEP1;
                end
            end
            ST_FIN:  state_nx_s = ST_LOAD;
            default: state_nx_s = ST_LOAD;
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        load_en_s    = 1'b0;
        init_en_s    = 1'b0;
        sweep_en_s   = 1'b0;
        commit1_en_s = 1'b0;
        commit2_en_s = 1'b0;
        case (state_r)
            ST_LOAD:    load_en_s    = 1'b1;
            ST_INIT:    init_en_s    = 1'b1;
            ST_SWEEP1:  sweep_en_s   = 1'b1;
            ST_SWEEP2:  sweep_en_s   = 1'b1;
            ST_COMMIT1: commit1_en_s = 1'b1;
            ST_COMMIT2: commit2_en_s = 1'b1;
            default:    load_en_s    = 1'b0;
        endcase
        if (state_nx_s == ST_FIN) done_nx_s = 1'b1;
        else                      done_nx_s = 1'b0;
    end

    // Point buffer; deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (load_en_s && !RST) begin
            pt_mem_r[idx_r] <= {Y, X};
        end
    end

    // Search datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_r        <= IDX_ZERO;
            cand_r       <= 8'd0;
            cnt_r        <= IDX_ZERO;
            best_pos_r   <= 8'd0;
            best_cnt_r   <= IDX_ZERO;
            cur_cnt_r    <= IDX_ZERO;
            iter_r       <= IT_ZERO;
            iter_start_r <= IDX_ZERO;
            c1x_r        <= 4'd0;
            c1y_r        <= 4'd0;
            c2x_r        <= 4'd0;
            c2y_r        <= 4'd0;
            done_r       <= 1'b0;
        end else begin
            done_r <= done_nx_s;
            if (load_en_s) begin
                idx_r <= last_pt_s ? IDX_ZERO : idx_r + IDX_ONE;
            end else if (init_en_s) begin
                c1x_r        <= 4'd0;
                c1y_r        <= 4'd0;
                c2x_r        <= 4'd0;
                c2y_r        <= 4'd0;
                cur_cnt_r    <= IDX_ZERO;
                iter_r       <= IT_ZERO;
                iter_start_r <= IDX_ZERO;
                // First sweep starts from C1=(0,0) with nothing covered.
                best_pos_r   <= 8'd0;
                best_cnt_r   <= IDX_ZERO;
                idx_r        <= IDX_ZERO;
                cand_r       <= 8'd0;
                cnt_r        <= IDX_ZERO;
            end else if (sweep_en_s) begin
                if (last_pt_s) begin
                    idx_r  <= IDX_ZERO;
                    cnt_r  <= IDX_ZERO;
                    cand_r <= cand_r + 8'd1;
                    // Strict compare: ties keep the earlier winner.
                    if (cnt_nx_s > best_cnt_r) begin
                        best_pos_r <= cand_r;
                        best_cnt_r <= cnt_nx_s;
                    end else begin
                        best_pos_r <= best_pos_r;
                    end
                end else begin
                    idx_r <= idx_r + IDX_ONE;
                    cnt_r <= cnt_nx_s;
                end
            end else if (commit1_en_s) begin
                c1x_r      <= best_pos_r[3:0];
                c1y_r      <= best_pos_r[7:4];
                cur_cnt_r  <= best_cnt_r;
                // Next sweep moves C2 and starts from its current position.
                best_pos_r <= {c2y_r, c2x_r};
                idx_r      <= IDX_ZERO;
                cand_r     <= 8'd0;
                cnt_r      <= IDX_ZERO;
            end else if (commit2_en_s) begin
                c2x_r      <= best_pos_r[3:0];
                c2y_r      <= best_pos_r[7:4];
                cur_cnt_r  <= best_cnt_r;
                iter_r     <= iter_inc_s;
                if (state_nx_s == ST_SWEEP1) begin
                    iter_start_r <= best_cnt_r;
                end else begin
                    iter_start_r <= iter_start_r;
                end
                best_pos_r <= {c1y_r, c1x_r};
                idx_r      <= IDX_ZERO;
                cand_r     <= 8'd0;
                cnt_r      <= IDX_ZERO;
            end else begin
                idx_r <= IDX_ZERO;
            end
        end
    end

    assign C1X  = c1x_r;
    assign C1Y  = c1y_r;
    assign C2X  = c2x_r;
    assign C2Y  = c2y_r;
    assign DONE = done_r;

endmodule
